obf_key_injector: RTL and testbench
===================================

# obf_key_injector

Upstream companion to the key-locked obfuscated FSM. It drives the FSM's serial input `x`. After reset, or on request, it plays the unlock key sequence onto `x` bit by bit, then switches to a transparent valid/ready pass-through of functional data. It also counts the FSM's `out` detection pulses once the FSM is unlocked, so a bench or SoC wrapper can tell correct-key from wrong-key operation.

## Interface
- `KEY_LEN`, 5, number of key bits (2..16)
- `KEY`, 5'b01110, unlock key; bit `KEY_LEN-1` is applied first
- `IDLE_BIT`, 1'b0, value driven on `x_out` when no key bit or data bit is being presented
- `AUTO_START`, 1, 1 = begin injection on the first cycle after reset release
- `CNT_W`, 8, width of the detection counter
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request key injection; honoured only in IDLE
- `din`  in  1  functional data bit
- `din_valid`  in  1  `din` valid this cycle
- `din_ready`  out  1  block accepts `din` this cycle
- `x_out`  out  1  registered serial bit to the FSM `x` input
- `busy`  out  1  key injection in progress
- `unlocked`  out  1  key fully delivered; pass-through active
- `det_in`  in  1  FSM `out` (detection pulse)
- `det_clr`  in  1  synchronous clear of `det_count`
- `det_count`  out  CNT_W  saturating count of detections while unlocked

## Operation
- States: IDLE, INJECT, PASS. Index register `idx` is `ceil(log2(KEY_LEN))` bits.
- Reset (`rst_n`=0 at an edge) forces:
  - state=IDLE, idx=0, `x_out`=IDLE_BIT, `unlocked`=0, `det_count`=0.
  - Reset has priority over every other input.
- IDLE:
  - `busy`=0, `din_ready`=0, `x_out` holds IDLE_BIT.
  - Leaves for INJECT when `start`=1, or on the first edge with `rst_n`=1 if AUTO_START=1.
  - On that edge: idx←0, `x_out`←`KEY[KEY_LEN-1]`.
- INJECT:
  - `busy`=1, `din_ready`=0. `din` is ignored and `start` is ignored.
  - Each edge with idx<KEY_LEN-1: idx←idx+1, `x_out`←`KEY[KEY_LEN-2-idx]`.
  - Edge with idx==KEY_LEN-1: state←PASS, `unlocked`←1, `x_out`←(`din_valid` ? `din` : IDLE_BIT).
- PASS:
  - `din_ready`=1 (combinational from state).
  - Each edge: `x_out`←(`din_valid` ? `din` : IDLE_BIT).
  - Terminal state; `start` is ignored. Only reset leaves PASS.
- Detection counter:
  - On an edge with `det_clr`=1: `det_count`←0. Clear wins over a simultaneous `det_in`.
  - Otherwise, if `unlocked`=1, `det_in`=1 and `det_count`<2^CNT_W−1: increment.
  - Holds at 2^CNT_W−1.
  - `det_in` is ignored while locked.
- `busy`, `unlocked` and `det_count` are registered or derived only from registered state.

## Timing
- `x_out` is registered. A bit written at edge t is sampled by the FSM at edge t+1.
- Start edge t0: key bits appear on `x_out` during cycles t0..t0+KEY_LEN−1 (one bit per cycle, no gaps). The FSM consumes them at edges t0+1..t0+KEY_LEN.
- `unlocked` rises at edge t0+KEY_LEN. The first pass-through bit is accepted at that same edge if `din_valid`=1.
- Pass-through latency: `din` accepted at edge t appears on `x_out` from t until t+1 (1 cycle).
- AUTO_START=1: injection begins at the first edge where `rst_n`=1, so the first key bit is on `x_out` one cycle after reset release.
- Reset mid-injection: the sequence aborts and restarts from `KEY[KEY_LEN-1]`. The downstream FSM must be re-initialised alongside, since a partial key leaves it in its trap state.
- `det_count` updates one edge after the `det_in` cycle.

## Test plan
- Basic unlock: KEY=01110, AUTO_START=0; reset, then pulse `start` at t0. Required: `x_out`=0,1,1,1,0 on cycles t0..t0+4; `busy`=1 on those cycles; `unlocked`=1 from t0+5.
- Ignored inputs: during INJECT, assert `start`=1 and `din_valid`=1 with `din`=1. Required: `din_ready`=0, key sequence unchanged. After unlock, `start` pulses do not leave PASS.
- Pass-through: in PASS, drive `din`=1,0,(invalid),1 on consecutive cycles. Required: `x_out`=1,0,IDLE_BIT,1, each one cycle later.
- Integration with the FSM: after unlock, send nine valid 1s. Required: FSM pulses `out` on every third bit; `det_count`=3.
- Counter boundaries: CNT_W=2, send eight detections. Required: `det_count` saturates at 3. Then `det_clr`=1 together with `det_in`=1: required `det_count`=0 next cycle.
- Reset mid-injection: AUTO_START=1; drop `rst_n` during the 3rd key bit. Required next edge: `x_out`=IDLE_BIT, `unlocked`=0, `busy`=0. After release, the full 0,1,1,1,0 sequence replays from the first bit.

Source files
------------

// File: rtl/obf_key_injector.sv
// obf_key_injector: plays a fixed unlock key onto the serial input of a
// key-locked FSM, then passes functional data straight through with a
// valid/ready handshake. It also counts detection pulses from the FSM once
// the key has been fully delivered.
module obf_key_injector #(
    parameter int unsigned          KEY_LEN    = 5,
    parameter logic [KEY_LEN-1:0]   KEY        = 5'b01110,
    parameter logic                 IDLE_BIT   = 1'b0,
    parameter bit                   AUTO_START = 1'b1,
    parameter int unsigned          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             busy,
    output logic             unlocked,
    input  logic             det_in,
    input  logic             det_clr,
    output logic [CNT_W-1:0] det_count
);

    localparam int unsigned      IDX_W    = $clog2(KEY_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INJECT,
        S_PASS
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic [IDX_W-1:0] idx_inc;
    logic [KEY_LEN-1:0] key_shift;
    logic             x_nx;
    logic             pass_bit;
    // Set by reset when AUTO_START is enabled; consumed on the first edge
    // after reset release so IDLE launches injection exactly once.
    logic             auto_pend;

    // State register: FSM state, key index, registered serial bit, auto-start flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            x_out     <= IDLE_BIT;
            auto_pend <= AUTO_START;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            x_out     <= x_nx;
            auto_pend <= 1'b0;
        end
    end

    // Next-state logic: key sequencing and pass-through bit selection
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        x_nx      = x_out;
        pass_bit  = din_valid ? din : IDLE_BIT;
        idx_inc   = idx + 1'b1;
        // Next key bit is the MSB after shifting out the bits already sent;
        // idx_inc is only used while idx < KEY_LEN-1, so it never wraps.
        key_shift = KEY << idx_inc;
        case (state)
            S_IDLE: begin
                x_nx = IDLE_BIT;
                if (start || auto_pend) begin
                    state_nx = S_INJECT;
                    idx_nx   = '0;
                    x_nx     = KEY[KEY_LEN-1];
                end
            end
            S_INJECT: begin
                if (idx == IDX_LAST) begin
                    state_nx = S_PASS;
                    x_nx     = pass_bit;
                end else begin
                    idx_nx = idx_inc;
                    x_nx   = key_shift[KEY_LEN-1];
                end
            end
            S_PASS: begin
                x_nx = pass_bit;
            end
            default: begin
                state_nx = S_IDLE;
                idx_nx   = '0;
                x_nx     = IDLE_BIT;
            end
        endcase
    end

    // Output decode: status flags derived purely from registered state
    always_comb begin
        busy      = (state == S_INJECT);
        din_ready = (state == S_PASS);
        unlocked  = (state == S_PASS);
    end

    // Detection counter: clear has priority, saturates at all-ones, counts only while unlocked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            det_count <= '0;
        end else if (det_clr) begin
            det_count <= '0;
        end else if (unlocked && det_in && (det_count != '1)) begin
            det_count <= det_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_obf_key_injector.sv
// Directed self-checking bench for obf_key_injector. Three instances:
// u0 (AUTO_START=0, CNT_W=8), u1 (AUTO_START=0, CNT_W=2) sharing u0's
// inputs, and u2 (AUTO_START=1) with its own reset.
module tb_obf_key_injector;

    logic clk = 1'b0;
    logic rst_n, rst_n2;
    logic start, din, din_valid, det_in, det_clr;

    logic       rdy0, x0, busy0, unl0;
    logic [7:0] cnt0;
    logic       rdy1, x1, busy1, unl1;
    logic [1:0] cnt1;
    logic       rdy2, x2, busy2, unl2;
    logic [7:0] cnt2;

    int checks = 0;
    int errors = 0;

    logic [4:0] key_v = 5'b01110;

    always #5 clk = ~clk;

    obf_key_injector #(.KEY_LEN(5), .KEY(5'b01110), .IDLE_BIT(1'b0),
                       .AUTO_START(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .x_out(x0), .busy(busy0), .unlocked(unl0),
        .det_in(det_in), .det_clr(det_clr), .det_count(cnt0));

    obf_key_injector #(.KEY_LEN(5), .KEY(5'b01110), .IDLE_BIT(1'b0),
                       .AUTO_START(1'b0), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .x_out(x1), .busy(busy1), .unlocked(unl1),
        .det_in(det_in), .det_clr(det_clr), .det_count(cnt1));

    obf_key_injector #(.KEY_LEN(5), .KEY(5'b01110), .IDLE_BIT(1'b0),
                       .AUTO_START(1'b1), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n2), .start(1'b0), .din(1'b0), .din_valid(1'b0),
        .din_ready(rdy2), .x_out(x2), .busy(busy2), .unlocked(unl2),
        .det_in(1'b0), .det_clr(1'b0), .det_count(cnt2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n2 = 1'b0;
        start = 1'b0; din = 1'b0; din_valid = 1'b0; det_in = 1'b0; det_clr = 1'b0;
        tick(); tick();
        checks++; if (x0 !== 1'b0)   begin errors++; $display("FAIL reset_x: got %b want 0", x0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (unl0 !== 1'b0)  begin errors++; $display("FAIL reset_unlocked: got %b want 0", unl0); end
        checks++; if (rdy0 !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %b want 0", rdy0); end
        checks++; if (cnt0 !== 8'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", cnt0); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy_auto: got %b want 0", busy2); end
    endtask

    task automatic test_basic_unlock();
        rst_n = 1'b1;
        det_in = 1'b1;   // must be ignored while locked
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_no_autostart: busy got %b want 0", busy0); end
        checks++; if (cnt0 !== 8'd0)  begin errors++; $display("FAIL locked_det_ignored: got %0d want 0", cnt0); end
        start = 1'b1;
        tick();          // edge t0
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (x0 !== key_v[4-i]) begin errors++; $display("FAIL key_bit%0d: got %b want %b", i, x0, key_v[4-i]); end
            checks++; if (busy0 !== 1'b1)    begin errors++; $display("FAIL key_busy%0d: got %b want 1", i, busy0); end
            checks++; if (unl0 !== 1'b0)     begin errors++; $display("FAIL key_locked%0d: got %b want 0", i, unl0); end
            tick();
        end
        det_in = 1'b0;
        checks++; if (unl0 !== 1'b1)  begin errors++; $display("FAIL unlock: got %b want 1", unl0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL unlock_busy: got %b want 0", busy0); end
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL unlock_ready: got %b want 1", rdy0); end
        checks++; if (cnt0 !== 8'd0)  begin errors++; $display("FAIL inject_det_ignored: got %0d want 0", cnt0); end
    endtask

    task automatic test_ignored_inputs();
        rst_n = 1'b0;
        tick();
        checks++; if (unl0 !== 1'b0) begin errors++; $display("FAIL rst_from_pass: unlocked got %b want 0", unl0); end
        checks++; if (x0 !== 1'b0)   begin errors++; $display("FAIL rst_from_pass_x: got %b want 0", x0); end
        rst_n = 1'b1;
        start = 1'b1; din = 1'b1; din_valid = 1'b1;
        tick();          // edge t0; inputs held through injection
        for (int i = 0; i < 5; i++) begin
            checks++; if (x0 !== key_v[4-i]) begin errors++; $display("FAIL ign_key_bit%0d: got %b want %b", i, x0, key_v[4-i]); end
            checks++; if (rdy0 !== 1'b0)     begin errors++; $display("FAIL ign_ready%0d: got %b want 0", i, rdy0); end
            tick();
        end
        // din accepted at the unlock edge
        checks++; if (unl0 !== 1'b1) begin errors++; $display("FAIL ign_unlock: got %b want 1", unl0); end
        checks++; if (x0 !== 1'b1)   begin errors++; $display("FAIL first_pass_bit: got %b want 1", x0); end
        din_valid = 1'b0;
        tick(); tick();  // start still high in PASS
        start = 1'b0;
        checks++; if (unl0 !== 1'b1)  begin errors++; $display("FAIL start_in_pass: unlocked got %b want 1", unl0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL start_in_pass_busy: got %b want 0", busy0); end
        checks++; if (x0 !== 1'b0)    begin errors++; $display("FAIL pass_idle_bit: got %b want 0", x0); end
    endtask

    task automatic test_pass_through();
        logic [3:0] d_v   = 4'b1011;   // element i = d_v[i]: 1,1,0,1
        logic [3:0] val_v = 4'b1011;
        logic [3:0] exp_v = 4'b1001;
        // Sequence: din=1 valid, din=0 valid, din=1 invalid, din=1 valid
        d_v   = 4'b1101; // i0=1 i1=0 i2=1 i3=1
        val_v = 4'b1011; // i0=1 i1=1 i2=0 i3=1
        exp_v = 4'b1001; // i0=1 i1=0 i2=0 i3=1
        for (int i = 0; i < 4; i++) begin
            din = d_v[i]; din_valid = val_v[i];
            checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL pass_ready%0d: got %b want 1", i, rdy0); end
            tick();
            checks++; if (x0 !== exp_v[i]) begin errors++; $display("FAIL pass_bit%0d: got %b want %b", i, x0, exp_v[i]); end
        end
        din_valid = 1'b0; din = 1'b0;
    endtask

    task automatic test_detection();
        int ones = 0;
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL det_pre_clear: got %0d want 0", cnt0); end
        // Model of the downstream FSM: one out pulse per third 1 it samples
        for (int k = 0; k < 9; k++) begin
            din = 1'b1; din_valid = 1'b1;
            tick();
            if (x0 === 1'b1) ones++;
            det_in = (ones % 3 == 0) && (ones != 0) && (x0 === 1'b1);
        end
        din_valid = 1'b0; din = 1'b0;
        tick();
        det_in = 1'b0;
        tick();
        checks++; if (cnt0 !== 8'd3) begin errors++; $display("FAIL det_count9: got %0d want 3", cnt0); end
        checks++; if (cnt1 !== 2'd3) begin errors++; $display("FAIL det_count9_w2: got %0d want 3", cnt1); end
    endtask

    task automatic test_counter_sat();
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        det_in  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (cnt1 !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sat_w2_%0d: got %0d want %0d", k, cnt1, (k > 3) ? 3 : k); end
            checks++; if (cnt0 !== 8'(k)) begin errors++; $display("FAIL count_w8_%0d: got %0d want %0d", k, cnt0, k); end
        end
        det_clr = 1'b1;   // det_in still 1
        tick();
        det_clr = 1'b0; det_in = 1'b0;
        checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL clr_wins_w2: got %0d want 0", cnt1); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL clr_wins_w8: got %0d want 0", cnt0); end
    endtask

    task automatic test_reset_mid_injection();
        rst_n2 = 1'b1;
        tick();           // first edge with reset released launches injection
        checks++; if (x2 !== key_v[4]) begin errors++; $display("FAIL auto_first_bit: got %b want %b", x2, key_v[4]); end
        checks++; if (busy2 !== 1'b1)  begin errors++; $display("FAIL auto_busy: got %b want 1", busy2); end
        tick(); tick();   // third key bit on x_out
        checks++; if (x2 !== key_v[2]) begin errors++; $display("FAIL auto_third_bit: got %b want %b", x2, key_v[2]); end
        rst_n2 = 1'b0;
        tick();
        checks++; if (x2 !== 1'b0)    begin errors++; $display("FAIL abort_x: got %b want 0", x2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy2); end
        checks++; if (unl2 !== 1'b0)  begin errors++; $display("FAIL abort_unlocked: got %b want 0", unl2); end
        rst_n2 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (x2 !== key_v[4-i]) begin errors++; $display("FAIL replay_bit%0d: got %b want %b", i, x2, key_v[4-i]); end
            checks++; if (busy2 !== 1'b1)    begin errors++; $display("FAIL replay_busy%0d: got %b want 1", i, busy2); end
            tick();
        end
        checks++; if (unl2 !== 1'b1) begin errors++; $display("FAIL replay_unlock: got %b want 1", unl2); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL replay_ready: got %b want 1", rdy2); end
    endtask

    initial begin
        test_reset();
        test_basic_unlock();
        test_ignored_inputs();
        test_pass_through();
        test_detection();
        test_counter_sat();
        test_reset_mid_injection();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
